// File: rtl/ysyx_22040125_wbu_if.sv
// Writeback-unit bus bundle: EXU/LSU writeback requests, register-file write port,
// decode-stage hazard query and queue status.
interface ysyx_22040125_wbu_if;
  localparam int unsigned RW   = 5;
  localparam int unsigned XLEN = 64;

  logic            exu_valid;
  logic [RW-1:0]   exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;

  logic            lsu_valid;
  logic [RW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            en;
  logic [RW-1:0]   addr_rd;
  logic [XLEN-1:0] data_rd;

  logic [RW-1:0]   q_rs1;
  logic [RW-1:0]   q_rs2;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            fwd_hit_rs1;
  logic [XLEN-1:0] fwd_data_rs1;
  logic            fwd_hit_rs2;
  logic [XLEN-1:0] fwd_data_rs2;

  logic            empty;
  logic            full;

  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, q_rs1, q_rs2,
    output exu_ready, lsu_ready, en, addr_rd, data_rd, busy_rs1, busy_rs2,
           fwd_hit_rs1, fwd_data_rs1, fwd_hit_rs2, fwd_data_rs2, empty, full
  );

  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, q_rs1, q_rs2,
    input  exu_ready, lsu_ready, en, addr_rd, data_rd, busy_rs1, busy_rs2,
           fwd_hit_rs1, fwd_data_rs1, fwd_hit_rs2, fwd_data_rs2, empty, full
  );
endinterface

// File: rtl/ysyx_22040125_wbu.sv
// Writeback unit: 4-entry in-order queue merging EXU/LSU results into one regfile write port.
// Define YSYX_22040125_WBU_FWD_EN to enable forwarding of pending values to decode.
module ysyx_22040125_wbu (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22040125_wbu_if.slave        wb
);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 5;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            has_room_c;
  logic            lsu_fire_c;
  logic            exu_fire_c;
  logic            push_c;
  logic            pop_c;
  wb_entry_t       push_entry_c;
  wb_entry_t       head_c;
  logic            busy1_c, busy2_c;

  // Full blocks both producers even while draining; LSU wins a tie.
  assign has_room_c   = rst_n && (count_q < CW'(DEPTH));
  assign lsu_fire_c   = wb.lsu_valid && has_room_c;
  assign exu_fire_c   = wb.exu_valid && has_room_c && !wb.lsu_valid;
  assign push_entry_c = lsu_fire_c ? wb_entry_t'{rd: wb.lsu_rd, data: wb.lsu_data}
                                   : wb_entry_t'{rd: wb.exu_rd, data: wb.exu_data};
  assign push_c       = (lsu_fire_c || exu_fire_c) && (push_entry_c.rd != '0);
  assign pop_c        = (count_q != '0);

  assign wb.lsu_ready = has_room_c;
  assign wb.exu_ready = has_room_c && !wb.lsu_valid;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (push_c) begin
      mem_d[wptr_q] = push_entry_c;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_c     = mem_q[rptr_q];
  assign wb.en      = pop_c;
  assign wb.addr_rd = pop_c ? head_c.rd   : '0;
  assign wb.data_rd = pop_c ? head_c.data : '0;
  assign wb.empty   = (count_q == '0);
  assign wb.full    = (count_q == CW'(DEPTH));

`ifdef YSYX_22040125_WBU_FWD_EN
  logic [XLEN-1:0] fwd1_c, fwd2_c;
`endif

  // Scan oldest to youngest so the last match is the youngest pending value.
  always_comb begin
    busy1_c = 1'b0;
    busy2_c = 1'b0;
`ifdef YSYX_22040125_WBU_FWD_EN
    fwd1_c  = '0;
    fwd2_c  = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((wb.q_rs1 != '0) && (mem_q[rptr_q + PW'(i)].rd == wb.q_rs1)) begin
          busy1_c = 1'b1;
`ifdef YSYX_22040125_WBU_FWD_EN
          fwd1_c  = mem_q[rptr_q + PW'(i)].data;
`endif
        end
        if ((wb.q_rs2 != '0) && (mem_q[rptr_q + PW'(i)].rd == wb.q_rs2)) begin
          busy2_c = 1'b1;
`ifdef YSYX_22040125_WBU_FWD_EN
          fwd2_c  = mem_q[rptr_q + PW'(i)].data;
`endif
        end
      end
    end
  end

  assign wb.busy_rs1 = busy1_c;
  assign wb.busy_rs2 = busy2_c;

`ifdef YSYX_22040125_WBU_FWD_EN
  assign wb.fwd_hit_rs1  = busy1_c;
  assign wb.fwd_hit_rs2  = busy2_c;
  assign wb.fwd_data_rs1 = fwd1_c;
  assign wb.fwd_data_rs2 = fwd2_c;
`else
  assign wb.fwd_hit_rs1  = 1'b0;
  assign wb.fwd_hit_rs2  = 1'b0;
  assign wb.fwd_data_rs1 = '0;
  assign wb.fwd_data_rs2 = '0;
`endif
endmodule
